// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two requesters.
// Operands are registered toward the ALU, and the result is captured once and returned over a response handshake.
//
// state | meaning
// IDLE  | waiting for a request; grants one requester combinationally
// EXEC  | ALU inputs registered; capture alu_y at the next edge
// RESP  | result held for the owner until its response handshake
module alu_share_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_sel,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_sel,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_y,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state;
  logic   owner;
  logic   last_gnt;
  logic   gnt0;
  logic   gnt1;
  logic   resp_done;

  // last_gnt resets to 1 so requester 0 wins the first contention
  assign gnt0 = req0_valid && (!req1_valid || last_gnt);
  assign gnt1 = req1_valid && (!req0_valid || !last_gnt);

  assign req0_ready = (state == IDLE) && gnt0;
  assign req1_ready = (state == IDLE) && gnt1;

  assign resp_done = (resp0_valid && resp0_ready) || (resp1_valid && resp1_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last_gnt    <= 1'b1;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_sel     <= 2'b00;
      resp_data   <= '0;
      resp_zero   <= 1'b0;
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt0) begin
            alu_a    <= req0_a;
            alu_b    <= req0_b;
            alu_sel  <= req0_sel;
            owner    <= 1'b0;
            last_gnt <= 1'b0;
            busy     <= 1'b1;
            state    <= EXEC;
          end else if (gnt1) begin
            alu_a    <= req1_a;
            alu_b    <= req1_b;
            alu_sel  <= req1_sel;
            owner    <= 1'b1;
            last_gnt <= 1'b1;
            busy     <= 1'b1;
            state    <= EXEC;
          end
        end
        EXEC: begin
          resp_data   <= alu_y;
          resp_zero   <= (alu_y == '0);
          resp0_valid <= !owner;
          resp1_valid <= owner;
          state       <= RESP;
        end
        RESP: begin
          if (resp_done) begin
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small external 4-bit ALU.
// Expected results are hand-computed constants.
module tb_alu_share_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [1:0] req0_sel, req1_sel, alu_sel;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic       resp0_valid, resp0_ready, resp1_valid, resp1_ready;
  logic [3:0] resp_data, alu_a, alu_b, alu_y;
  logic       resp_zero, busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // the shared ALU that sits outside the arbiter
  always_comb begin
    alu_y = 4'h0;
    case (alu_sel)
      2'b00: alu_y = alu_a + alu_b;
      2'b01: alu_y = alu_a - alu_b;
      2'b10: alu_y = alu_a | alu_b;
      2'b11: alu_y = alu_a & alu_b;
      default: alu_y = 4'h0;
    endcase
  end

  alu_share_arbiter #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sel(req0_sel),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sel(req1_sel),
    .req1_a(req1_a), .req1_b(req1_b),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp_data(resp_data), .resp_zero(resp_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_y(alu_y),
    .busy(busy)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, " busy"}, busy, 0);
    check_val({tag, " resp0_valid"}, resp0_valid, 0);
    check_val({tag, " resp1_valid"}, resp1_valid, 0);
    check_val({tag, " resp_data"}, resp_data, 0);
    check_val({tag, " resp_zero"}, resp_zero, 0);
    check_val({tag, " alu_a"}, alu_a, 0);
    check_val({tag, " alu_b"}, alu_b, 0);
    check_val({tag, " alu_sel"}, alu_sel, 0);
    check_val({tag, " req0_ready"}, req0_ready, 0);
    check_val({tag, " req1_ready"}, req1_ready, 0);
  endtask

  task automatic do_op(input int who, input logic [1:0] sel, input logic [3:0] a,
                       input logic [3:0] b, input logic [3:0] ey, input logic ez);
    if (who == 0) begin
      req0_valid = 1'b1; req0_sel = sel; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_sel = sel; req1_a = a; req1_b = b;
    end
    #1;
    check_val("op req0_ready", req0_ready, (who == 0));
    check_val("op req1_ready", req1_ready, (who == 1));
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check_val("op alu_a", alu_a, a);
    check_val("op alu_b", alu_b, b);
    check_val("op alu_sel", alu_sel, sel);
    check_val("op busy exec", busy, 1);
    check_val("op resp0_valid exec", resp0_valid, 0);
    step();
    check_val("op resp0_valid", resp0_valid, (who == 0));
    check_val("op resp1_valid", resp1_valid, (who == 1));
    check_val("op resp_data", resp_data, ey);
    check_val("op resp_zero", resp_zero, ez);
    if (who == 0) resp0_ready = 1'b1; else resp1_ready = 1'b1;
    step();
    resp0_ready = 1'b0;
    resp1_ready = 1'b0;
    check_val("op busy done", busy, 0);
    check_val("op resp valid cleared", resp0_valid | resp1_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 0; req0_sel = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_sel = 0; req1_a = 0; req1_b = 0;
    resp0_ready = 0; resp1_ready = 0;
    #2;
    check_reset_vals("reset");
    step();
    step();
    rst_n = 1'b1;
    step();

    // single add with wrap: 9 + 8 = 1
    do_op(0, 2'b00, 4'h9, 4'h8, 4'h1, 1'b0);
    // subtract: 3 - 5 = E, then 7 - 7 = 0 with zero flag
    do_op(1, 2'b01, 4'h3, 4'h5, 4'hE, 1'b0);
    do_op(1, 2'b01, 4'h7, 4'h7, 4'h0, 1'b1);

    // contention from fresh reset, both held throughout
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    req0_valid = 1; req0_sel = 2'b10; req0_a = 4'hA; req0_b = 4'h5;
    req1_valid = 1; req1_sel = 2'b11; req1_a = 4'hC; req1_b = 4'h6;
    #1;
    check_val("cont first req0_ready", req0_ready, 1);
    check_val("cont first req1_ready", req1_ready, 0);
    step();
    check_val("cont exec alu_sel", alu_sel, 2'b10);
    check_val("cont exec req1_ready", req1_ready, 0);
    step();
    check_val("cont r0 resp0_valid", resp0_valid, 1);
    check_val("cont r0 data", resp_data, 4'hF);
    resp0_ready = 1;
    step();
    resp0_ready = 0;
    check_val("cont second req1_ready", req1_ready, 1);
    check_val("cont second req0_ready", req0_ready, 0);
    step();
    step();
    check_val("cont r1 resp1_valid", resp1_valid, 1);
    check_val("cont r1 resp0_valid", resp0_valid, 0);
    check_val("cont r1 data", resp_data, 4'h4);
    check_val("cont r1 zero", resp_zero, 0);
    resp1_ready = 1;
    step();
    resp1_ready = 0;
    check_val("cont third req0_ready", req0_ready, 1);
    check_val("cont third req1_ready", req1_ready, 0);
    req0_valid = 0;
    req1_valid = 0;
    #1;
    check_val("withdrawn req0_ready", req0_ready, 0);
    step();
    check_val("withdrawn busy", busy, 0);

    // back-pressure plus non-owner ready pulse
    req0_valid = 1; req0_sel = 2'b00; req0_a = 4'h1; req0_b = 4'h2;
    step();
    req0_valid = 0;
    step();
    req1_valid = 1; req1_sel = 2'b00; req1_a = 4'h0; req1_b = 4'h0;
    for (int i = 0; i < 5; i++) begin
      resp1_ready = (i == 2);
      #1;
      check_val("bp resp0_valid", resp0_valid, 1);
      check_val("bp resp_data", resp_data, 4'h3);
      check_val("bp busy", busy, 1);
      check_val("bp req1_ready", req1_ready, 0);
      step();
    end
    resp1_ready = 0;
    req1_valid = 0;
    check_val("bp still held", resp0_valid, 1);
    resp0_ready = 1;
    step();
    resp0_ready = 0;
    check_val("bp released busy", busy, 0);
    check_val("bp released resp0_valid", resp0_valid, 0);

    // reset during EXEC drops the op
    req1_valid = 1; req1_sel = 2'b00; req1_a = 4'h3; req1_b = 4'h4;
    step();
    req1_valid = 0;
    check_val("rexec busy before", busy, 1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("rexec");
    step();
    step();
    check_val("rexec no resp1", resp1_valid, 0);
    rst_n = 1'b1;
    step();
    do_op(1, 2'b10, 4'h3, 4'h4, 4'h7, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
